// File: rtl/ps2_ascii_fifo_if.sv
// Byte/character handshake bundle between the PS/2 receiver, the
// scan-code decoder FIFO and the CPU I/O port.
interface ps2_ascii_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    scancode;
    logic          ready;
    logic          rd_en;
    logic [7:0]    ascii;
    logic          valid;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output scancode, ready, rd_en,
        input  ascii, valid, count, overflow
    );

    modport slave (
        input  scancode, ready, rd_en,
        output ascii, valid, count, overflow
    );
endinterface

// File: rtl/ps2_ascii_fifo.sv
// PS/2 set-2 scan-code to ASCII decoder feeding a show-ahead FIFO.
// Optional caps-lock support is enabled with `define KBD_CAPS_LOCK_EN.
module ps2_ascii_fifo #(
    parameter int DEPTH = 16
) (
    input  logic            CLOCK_50,
    input  logic            rst_n,
    ps2_ascii_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    // {mapped, is_letter, unshifted, shifted}
    function automatic logic [17:0] xlate(input logic [7:0] sc);
        unique case (sc)
            8'h1C: xlate = {2'b11, "a", "A"};
            8'h32: xlate = {2'b11, "b", "B"};
            8'h21: xlate = {2'b11, "c", "C"};
            8'h23: xlate = {2'b11, "d", "D"};
            8'h24: xlate = {2'b11, "e", "E"};
            8'h2B: xlate = {2'b11, "f", "F"};
            8'h34: xlate = {2'b11, "g", "G"};
            8'h33: xlate = {2'b11, "h", "H"};
            8'h43: xlate = {2'b11, "i", "I"};
            8'h3B: xlate = {2'b11, "j", "J"};
            8'h42: xlate = {2'b11, "k", "K"};
            8'h4B: xlate = {2'b11, "l", "L"};
            8'h3A: xlate = {2'b11, "m", "M"};
            8'h31: xlate = {2'b11, "n", "N"};
            8'h44: xlate = {2'b11, "o", "O"};
            8'h4D: xlate = {2'b11, "p", "P"};
            8'h15: xlate = {2'b11, "q", "Q"};
            8'h2D: xlate = {2'b11, "r", "R"};
            8'h1B: xlate = {2'b11, "s", "S"};
            8'h2C: xlate = {2'b11, "t", "T"};
            8'h3C: xlate = {2'b11, "u", "U"};
            8'h2A: xlate = {2'b11, "v", "V"};
            8'h1D: xlate = {2'b11, "w", "W"};
            8'h22: xlate = {2'b11, "x", "X"};
            8'h35: xlate = {2'b11, "y", "Y"};
            8'h1A: xlate = {2'b11, "z", "Z"};
            8'h16: xlate = {2'b10, "1", "!"};
            8'h1E: xlate = {2'b10, "2", "@"};
            8'h26: xlate = {2'b10, "3", "#"};
            8'h25: xlate = {2'b10, "4", "$"};
            8'h2E: xlate = {2'b10, "5", "%"};
            8'h36: xlate = {2'b10, "6", "^"};
            8'h3D: xlate = {2'b10, "7", "&"};
            8'h3E: xlate = {2'b10, "8", "*"};
            8'h46: xlate = {2'b10, "9", "("};
            8'h45: xlate = {2'b10, "0", ")"};
            8'h4E: xlate = {2'b10, "-", "_"};
            8'h55: xlate = {2'b10, "=", "+"};
            8'h54: xlate = {2'b10, "[", "{"};
            8'h5B: xlate = {2'b10, "]", "}"};
            8'h5D: xlate = {2'b10, "\\", "|"};
            8'h4C: xlate = {2'b10, ";", ":"};
            8'h52: xlate = {2'b10, "'", "\""};
            8'h41: xlate = {2'b10, ",", "<"};
            8'h49: xlate = {2'b10, ".", ">"};
            8'h4A: xlate = {2'b10, "/", "?"};
            8'h0E: xlate = {2'b10, 8'h60, "~"};
            8'h29: xlate = {2'b10, 8'h20, 8'h20};
            8'h5A: xlate = {2'b10, 8'h0D, 8'h0D};
            8'h66: xlate = {2'b10, 8'h08, 8'h08};
            8'h0D: xlate = {2'b10, 8'h09, 8'h09};
            8'h76: xlate = {2'b10, 8'h1B, 8'h1B};
            default: xlate = 18'd0;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic          push, upper, hit, letter;
    logic [7:0]    push_data, lo_c, hi_c;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_q;
    logic          ovf_q, do_push, do_pop, full;
    logic [7:0]    sc;

    assign sc = bus.scancode;
    assign {hit, letter, lo_c, hi_c} = xlate(sc);

`ifdef KBD_CAPS_LOCK_EN
    logic caps_q, caps_d, held_q, held_d;
    assign upper = letter ? ((lshift_q | rshift_q) ^ caps_q)
                          : (lshift_q | rshift_q);
`else
    assign upper = lshift_q | rshift_q;
`endif

    always_comb begin
        state_d   = state_q;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        push      = 1'b0;
        push_data = upper ? hi_c : lo_c;
`ifdef KBD_CAPS_LOCK_EN
        caps_d    = caps_q;
        held_d    = held_q;
`endif
        if (bus.ready) begin
            unique case (state_q)
                IDLE: begin
                    if (sc == 8'hF0) state_d = BRK;
                    else if (sc == 8'hE0) state_d = EXT;
                    else if (sc == 8'h12) lshift_d = 1'b1;
                    else if (sc == 8'h59) rshift_d = 1'b1;
`ifdef KBD_CAPS_LOCK_EN
                    else if (sc == 8'h58) begin
                        if (!held_q) caps_d = ~caps_q;
                        held_d = 1'b1;
                    end
`endif
                    else if (hit) push = 1'b1;
                end
                BRK: begin
                    state_d = IDLE;
                    if (sc == 8'h12) lshift_d = 1'b0;
                    if (sc == 8'h59) rshift_d = 1'b0;
`ifdef KBD_CAPS_LOCK_EN
                    if (sc == 8'h58) held_d = 1'b0;
`endif
                end
                EXT: begin
                    if (sc == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else begin
                        state_d = IDLE;
                        if (sc == 8'h5A) begin
                            push      = 1'b1;
                            push_data = 8'h0D;
                        end else if (sc == 8'h4A) begin
                            push      = 1'b1;
                            push_data = "/";
                        end
                    end
                end
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
`ifdef KBD_CAPS_LOCK_EN
            caps_q   <= 1'b0;
            held_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
`ifdef KBD_CAPS_LOCK_EN
            caps_q   <= caps_d;
            held_q   <= held_d;
`endif
        end
    end

    // A pop on a full FIFO frees the slot the same-edge push lands in.
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = bus.rd_en && (count_q != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
            if (push && !do_push) ovf_q <= 1'b1;
        end
    end

    assign bus.valid    = (count_q != '0);
    assign bus.ascii    = bus.valid ? mem[rd_ptr] : 8'h00;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Directed self-checking bench for the PS/2 ASCII FIFO.
module tb_ps2_ascii_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ps2_ascii_fifo_if #(.DEPTH(DEPTH)) bus ();

    ps2_ascii_fifo #(.DEPTH(DEPTH)) dut (
        .CLOCK_50(clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consecutive calls keep ready high across edges (back-to-back bytes).
    task automatic send(input logic [7:0] b);
        bus.ready    = 1'b1;
        bus.scancode = b;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, {24'd0, bus.ascii}, {24'd0, exp});
        pop();
    endtask

    initial begin
        bus.scancode = 8'h00;
        bus.ready    = 1'b0;
        bus.rd_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ascii", bus.ascii, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(8'h1C); send(8'hF0); send(8'h1C);
        chk("mkbrk_count", bus.count, 1);
        chk("mkbrk_valid", bus.valid, 1);
        chk("mkbrk_ascii", bus.ascii, 8'h61);
        pop();
        chk("pop_valid", bus.valid, 0);
        chk("pop_count", bus.count, 0);

        send(8'h12); send(8'h1C); send(8'h16);
        send(8'hF0); send(8'h12); send(8'h1C);
        chk("shift_count", bus.count, 3);
        pop_chk("shift_A", 8'h41);
        pop_chk("shift_bang", 8'h21);
        pop_chk("shift_rel_a", 8'h61);
        chk("shift_empty", bus.count, 0);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h5A);
        chk("ext_count", bus.count, 1);
        pop_chk("ext_enter", 8'h0D);
        send(8'h1C);
        pop_chk("ext_after_a", 8'h61);

        send(8'hE0); send(8'h4A);
        send(8'h59); send(8'h52); send(8'hF0); send(8'h59);
        send(8'h52); send(8'h58);
        chk("misc_count", bus.count, 3);
        pop_chk("kp_slash", 8'h2F);
        pop_chk("rshift_dq", 8'h22);
        pop_chk("quote", 8'h27);

        for (int i = 0; i < DEPTH; i++) send(8'h1C);
        chk("full_count", bus.count, DEPTH);
        chk("full_no_ovf", bus.overflow, 0);
        send(8'h1C);
        chk("ovf_count", bus.count, DEPTH);
        chk("ovf_set", bus.overflow, 1);
        bus.rd_en = 1'b1;
        send(8'h16);
        bus.rd_en = 1'b0;
        chk("full_rw_count", bus.count, DEPTH);
        chk("full_rw_ovf", bus.overflow, 1);
        for (int i = 0; i < DEPTH - 1; i++) pop();
        chk("drain_count", bus.count, 1);
        pop_chk("drain_last", 8'h31);
        chk("drain_empty", bus.valid, 0);
        pop();
        chk("empty_pop", bus.count, 0);

        send(8'h1C); send(8'h1C); send(8'hF0);
        rst_n = 1'b0;
        #2;
        chk("arst_count", bus.count, 0);
        chk("arst_valid", bus.valid, 0);
        chk("arst_ascii", bus.ascii, 0);
        chk("arst_ovf", bus.overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(8'h1C);
        chk("post_rst_count", bus.count, 1);
        pop_chk("post_rst_a", 8'h61);

        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        send(8'h1C); send(8'h12); send(8'h1C);
        send(8'hF0); send(8'h12);
        chk("caps_count", bus.count, 2);
`ifdef KBD_CAPS_LOCK_EN
        pop_chk("caps_first", 8'h41);
        pop_chk("caps_second", 8'h61);
`else
        pop_chk("caps_first", 8'h61);
        pop_chk("caps_second", 8'h41);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
